// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl
// -----------------------------------------------------------------------------
// Mispredict recovery sequencer for the reorder buffer.
//
// The ROB head entry is watched. When it is complete and flagged as a branch
// or load mispredict, a pipeline-wide flush is held for FLUSH_CYCLES cycles.
// A single redirect is then offered to fetch until fetch accepts it.
//
// While idle, a side tracker records the correct target of the oldest
// mispredicted branch reported by ALU writebacks. This means the redirect PC
// is already known when that branch reaches the head.
//
// Ports:
//   clk, rst_aL            clock, synchronous active-low reset
//   head_*                 ROB head entry: valid, id, pc, completed,
//                          branch/load mispredict flags
//   alu_wb_*               ALU writeback: valid, rob id, mispredict flag,
//                          correct branch target
//   redirect_ready         fetch accepts the redirect
//   flush                  clear ROB pointers, IIQ, LSQ and fetch queue
//   stall_dispatch         block dispatch enqueue
//   redirect_valid/_pc     restart request to fetch
//   recovery_busy          recovery sequence in progress
//   recovery_err           sticky: a branch recovered without a captured target
//   n_br_recoveries        saturating count of branch recoveries
//   n_ld_recoveries        saturating count of load recoveries
// -----------------------------------------------------------------------------
module rob_recovery_ctrl #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    head_valid,
  input  logic [ROB_ID_WIDTH-1:0] head_rob_id,
  input  logic [PC_WIDTH-1:0]     head_pc,
  input  logic                    head_reg_ready,
  input  logic                    head_br_mispredict,
  input  logic                    head_ld_mispredict,
  input  logic                    alu_wb_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_wb_rob_id,
  input  logic                    alu_wb_br_mispredict,
  input  logic [PC_WIDTH-1:0]     alu_wb_br_target,
  input  logic                    redirect_ready,
  output logic                    flush,
  output logic                    stall_dispatch,
  output logic                    redirect_valid,
  output logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    recovery_busy,
  output logic                    recovery_err,
  output logic [15:0]             n_br_recoveries,
  output logic [15:0]             n_ld_recoveries
);

  // The counter only needs to hold FLUSH_CYCLES-1.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    tgt_valid;
  logic [ROB_ID_WIDTH-1:0] tgt_id;
  logic [PC_WIDTH-1:0]     tgt_pc;

  logic                    is_idle;
  logic                    trigger;
  logic                    capture;
  logic                    tgt_match;
  logic [ROB_ID_WIDTH-1:0] wb_age;
  logic [ROB_ID_WIDTH-1:0] tgt_age;

  assign is_idle = (state_q == ST_IDLE);

  // A trigger can only start a recovery from IDLE. Once the sequence is running,
  // the head is ignored.
  assign trigger = is_idle & head_valid & head_reg_ready &
                   (head_br_mispredict | head_ld_mispredict);

  // Age is the distance from the head, modulo the ROB depth. The subtraction
  // wraps naturally in ROB_ID_WIDTH bits, so id 15 is older than id 1 when the
  // head is at 14.
  assign wb_age  = alu_wb_rob_id - head_rob_id;
  assign tgt_age = tgt_id - head_rob_id;

  // An equal age means the same entry, so a later report replaces the earlier one.
  assign capture = is_idle & alu_wb_valid & alu_wb_br_mispredict &
                   (!tgt_valid | (wb_age <= tgt_age));

  assign tgt_match = tgt_valid & (tgt_id == head_rob_id);

  // Next-state logic. The flush counter is loaded on entry, so FLUSH lasts
  // exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Oldest-target tracker. When a trigger occurs, the tracker is cleared even
  // if a capture happens in the same cycle. The trigger has already used the
  // values from before the capture. After a flush, every tracked branch is gone.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      tgt_valid <= 1'b0;
      tgt_id    <= '0;
      tgt_pc    <= '0;
    end else if (trigger) begin
      tgt_valid <= 1'b0;
    end else if (capture) begin
      tgt_valid <= 1'b1;
      tgt_id    <= alu_wb_rob_id;
      tgt_pc    <= alu_wb_br_target;
    end
  end

  // Recovery bookkeeping is latched on the edge that enters FLUSH. This keeps
  // redirect_pc stable for the rest of the sequence. A load refetches itself
  // and takes priority when both flags are set. A branch with no captured
  // target falls back to the fall-through PC and raises the sticky error.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      redirect_pc     <= '0;
      recovery_err    <= 1'b0;
      n_br_recoveries <= '0;
      n_ld_recoveries <= '0;
    end else if (trigger) begin
      if (head_ld_mispredict) begin
        redirect_pc <= head_pc;
        if (n_ld_recoveries != 16'hFFFF) begin
          n_ld_recoveries <= n_ld_recoveries + 16'd1;
        end
      end else begin
        if (tgt_match) begin
          redirect_pc <= tgt_pc;
        end else begin
          redirect_pc  <= head_pc + PC_WIDTH'(4);
          recovery_err <= 1'b1;
        end
        if (n_br_recoveries != 16'hFFFF) begin
          n_br_recoveries <= n_br_recoveries + 16'd1;
        end
      end
    end
  end

  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign recovery_busy  = !is_idle;
  assign stall_dispatch = !is_idle | trigger;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb_rob_recovery_ctrl
// -----------------------------------------------------------------------------
// Directed testbench for rob_recovery_ctrl with the default parameters
// (ROB_ID_WIDTH=4, PC_WIDTH=32, FLUSH_CYCLES=2).
//
// Inputs change 1 time unit after each rising edge. Outputs are checked once
// the inputs have settled and before the next edge.
// -----------------------------------------------------------------------------
module tb_rob_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        head_valid;
  logic [3:0]  head_rob_id;
  logic [31:0] head_pc;
  logic        head_reg_ready;
  logic        head_br_mispredict;
  logic        head_ld_mispredict;
  logic        alu_wb_valid;
  logic [3:0]  alu_wb_rob_id;
  logic        alu_wb_br_mispredict;
  logic [31:0] alu_wb_br_target;
  logic        redirect_ready;
  logic        flush;
  logic        stall_dispatch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        recovery_busy;
  logic        recovery_err;
  logic [15:0] n_br_recoveries;
  logic [15:0] n_ld_recoveries;

  int n_checks = 0;
  int n_fails  = 0;

  rob_recovery_ctrl #(
    .ROB_ID_WIDTH(4),
    .PC_WIDTH(32),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk                 (clk),
    .rst_aL              (rst_aL),
    .head_valid          (head_valid),
    .head_rob_id         (head_rob_id),
    .head_pc             (head_pc),
    .head_reg_ready      (head_reg_ready),
    .head_br_mispredict  (head_br_mispredict),
    .head_ld_mispredict  (head_ld_mispredict),
    .alu_wb_valid        (alu_wb_valid),
    .alu_wb_rob_id       (alu_wb_rob_id),
    .alu_wb_br_mispredict(alu_wb_br_mispredict),
    .alu_wb_br_target    (alu_wb_br_target),
    .redirect_ready      (redirect_ready),
    .flush               (flush),
    .stall_dispatch      (stall_dispatch),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .recovery_busy       (recovery_busy),
    .recovery_err        (recovery_err),
    .n_br_recoveries     (n_br_recoveries),
    .n_ld_recoveries     (n_ld_recoveries)
  );

  always #5 clk = ~clk;

  // Every comparison goes through this task, which counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the ROB head fields and lets the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [3:0] id, input logic [31:0] pc,
                               input logic rdy, input logic br, input logic ld);
    head_valid         = v;
    head_rob_id        = id;
    head_pc            = pc;
    head_reg_ready     = rdy;
    head_br_mispredict = br;
    head_ld_mispredict = ld;
    #1;
  endtask

  task automatic applyWriteback(input logic v, input logic [3:0] id, input logic [31:0] tgt);
    alu_wb_valid         = v;
    alu_wb_rob_id        = id;
    alu_wb_br_mispredict = v;
    alu_wb_br_target     = tgt;
    #1;
  endtask

  // Runs a recovery whose trigger is currently applied. The sequence is:
  // two flush cycles, then a redirect that is accepted at once, then IDLE.
  task automatic expectRecovery(input string tag, input logic [31:0] exp_pc);
    checkOutput({tag, "_stall_trig"}, 32'(stall_dispatch), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_flush1"}, 32'(flush), 32'd1);
    tick();
    checkOutput({tag, "_flush2"}, 32'(flush), 32'd1);
    tick();
    checkOutput({tag, "_flush_end"}, 32'(flush), 32'd0);
    checkOutput({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    checkOutput({tag, "_pc"}, redirect_pc, exp_pc);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput({tag, "_rv_done"}, 32'(redirect_valid), 32'd0);
    checkOutput({tag, "_busy_done"}, 32'(recovery_busy), 32'd0);
  endtask

  initial begin
    rst_aL         = 1'b0;
    redirect_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyWriteback(1'b0, 4'd0, 32'h0);
    tick();
    tick();
    rst_aL = 1'b1;
    tick();

    // Check the reset state.
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_stall", 32'(stall_dispatch), 32'd0);
    checkOutput("rst_rv", 32'(redirect_valid), 32'd0);
    checkOutput("rst_pc", redirect_pc, 32'h0);
    checkOutput("rst_busy", 32'(recovery_busy), 32'd0);
    checkOutput("rst_err", 32'(recovery_err), 32'd0);
    checkOutput("rst_nbr", 32'(n_br_recoveries), 32'd0);
    checkOutput("rst_nld", 32'(n_ld_recoveries), 32'd0);

    // Load refetch: the redirect restarts at the load's own PC.
    applyStimulus(1'b1, 4'd3, 32'h100, 1'b1, 1'b0, 1'b1);
    checkOutput("ld_stall_T", 32'(stall_dispatch), 32'd1);
    checkOutput("ld_busy_T", 32'(recovery_busy), 32'd0);
    checkOutput("ld_flush_T", 32'(flush), 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_flush1", 32'(flush), 32'd1);
    checkOutput("ld_stall1", 32'(stall_dispatch), 32'd1);
    checkOutput("ld_nld", 32'(n_ld_recoveries), 32'd1);
    checkOutput("ld_rv_early", 32'(redirect_valid), 32'd0);
    tick();
    checkOutput("ld_flush2", 32'(flush), 32'd1);
    tick();
    checkOutput("ld_flush3", 32'(flush), 32'd0);
    checkOutput("ld_rv", 32'(redirect_valid), 32'd1);
    checkOutput("ld_pc", redirect_pc, 32'h100);
    checkOutput("ld_stall_hs", 32'(stall_dispatch), 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput("ld_rv_after", 32'(redirect_valid), 32'd0);
    checkOutput("ld_stall_after", 32'(stall_dispatch), 32'd0);
    checkOutput("ld_busy_after", 32'(recovery_busy), 32'd0);

    // Oldest-target tracking across the wrap: with the head at 14,
    // id 15 (age 1) is older than id 1 (age 3).
    applyStimulus(1'b1, 4'd14, 32'h0, 1'b0, 1'b0, 1'b0);
    applyWriteback(1'b1, 4'd1, 32'h500);
    tick();
    applyWriteback(1'b1, 4'd15, 32'h300);
    tick();
    applyWriteback(1'b0, 4'd0, 32'h0);
    applyStimulus(1'b1, 4'd15, 32'h3C, 1'b1, 1'b1, 1'b0);
    expectRecovery("wrap", 32'h300);
    checkOutput("wrap_err", 32'(recovery_err), 32'd0);
    checkOutput("wrap_nbr", 32'(n_br_recoveries), 32'd1);

    // A younger writeback must not displace the captured older one.
    applyStimulus(1'b1, 4'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    applyWriteback(1'b1, 4'd5, 32'h200);
    tick();
    applyWriteback(1'b1, 4'd7, 32'h400);
    tick();
    applyWriteback(1'b0, 4'd0, 32'h0);
    applyStimulus(1'b1, 4'd5, 32'h50, 1'b1, 1'b1, 1'b0);
    expectRecovery("young", 32'h200);
    checkOutput("young_err", 32'(recovery_err), 32'd0);
    checkOutput("young_nbr", 32'(n_br_recoveries), 32'd2);

    // Missing target: the redirect falls through to head_pc+4 and sets the error flag.
    applyStimulus(1'b1, 4'd6, 32'h1FC, 1'b1, 1'b1, 1'b0);
    expectRecovery("miss", 32'h200);
    checkOutput("miss_err", 32'(recovery_err), 32'd1);
    checkOutput("miss_nbr", 32'(n_br_recoveries), 32'd3);

    // Both flags set: the load takes priority. Redirect is then held under backpressure.
    applyStimulus(1'b1, 4'd9, 32'h880, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd4, 32'h999, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("bp_rv%0d", i), 32'(redirect_valid), 32'd1);
      checkOutput($sformatf("bp_pc%0d", i), redirect_pc, 32'h880);
      checkOutput($sformatf("bp_stall%0d", i), 32'(stall_dispatch), 32'd1);
      tick();
    end
    checkOutput("bp_nld", 32'(n_ld_recoveries), 32'd2);
    checkOutput("bp_nbr", 32'(n_br_recoveries), 32'd3);
    checkOutput("bp_err_sticky", 32'(recovery_err), 32'd1);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_rv_hold", 32'(redirect_valid), 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput("bp_idle", 32'(recovery_busy), 32'd0);
    checkOutput("bp_rv_done", 32'(redirect_valid), 32'd0);

    // Reset asserted in the middle of a recovery, during FLUSH.
    applyStimulus(1'b1, 4'd1, 32'h40, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_flush", 32'(flush), 32'd1);
    checkOutput("mid_nld", 32'(n_ld_recoveries), 32'd3);
    rst_aL = 1'b0;
    tick();
    checkOutput("mid_rst_flush", 32'(flush), 32'd0);
    checkOutput("mid_rst_busy", 32'(recovery_busy), 32'd0);
    checkOutput("mid_rst_rv", 32'(redirect_valid), 32'd0);
    checkOutput("mid_rst_nld", 32'(n_ld_recoveries), 32'd0);
    checkOutput("mid_rst_nbr", 32'(n_br_recoveries), 32'd0);
    checkOutput("mid_rst_err", 32'(recovery_err), 32'd0);
    checkOutput("mid_rst_pc", redirect_pc, 32'h0);
    checkOutput("mid_rst_tgt", 32'(dut.tgt_valid), 32'd0);
    rst_aL = 1'b1;
    tick();
    checkOutput("post_rst_stall", 32'(stall_dispatch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
